// File: rtl/dmem_block_responder.sv
// Block-granular data memory responder for the dcache: one read or write per request,
// busywait held for a fixed latency, then a single-cycle DONE before returning to idle.
module dmem_block_responder #(
  parameter int LATENCY = 5,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait,
  output logic              mem_error
);

  localparam int Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  logic [DATA_W-1:0] mem [Depth];

  logic req_one;
  assign req_one = mem_read ^ mem_write;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      mem_readdata <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_one) begin
            addr_q  <= mem_address;
            data_q  <= mem_writedata;
            write_q <= mem_write;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // Only latched request fields are used here; live inputs may change freely.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (write_q) begin
              mem[addr_q] <= data_q;
            end else begin
              mem_readdata <= mem[addr_q];
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          // Requester still drives the old request this cycle, so nothing is accepted.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Busywait is combinational in idle so the requester never sees a false idle cycle.
  always_comb begin
    mem_busywait = 1'b0;
    mem_error    = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_busywait = req_one;
        mem_error    = mem_read & mem_write;
      end
      StAccess: mem_busywait = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: a model memory supplies expected read data,
// which is queued at request time and compared when the DONE cycle is observed.
module tb_dmem_block_responder;

  localparam int LATENCY = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic        mem_error;

  dmem_block_responder #(
    .LATENCY(LATENCY),
    .ADDR_W (6),
    .DATA_W (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .mem_error    (mem_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [64];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          last_done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = '0;
    last_rd = '0;
    exp_q.delete();
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the edge that
  // follows the DONE cycle. keep leaves the request driven so the caller can chain.
  task automatic access(input bit wr, input logic [5:0] a, input logic [31:0] d,
                        input int drop_at, input bit keep);
    int          busy;
    bit          done;
    logic [31:0] exp;
    busy = 0;
    done = 0;
    mem_address   = a;
    mem_writedata = d;
    mem_read      = !wr;
    mem_write     = wr;
    if (wr) model[a] = d;
    else exp_q.push_back(model[a]);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (mem_busywait) begin
        busy++;
        if (busy == LATENCY + 1) check("rdata_held_busy", mem_readdata, last_rd);
        @(posedge clock);
        #1;
        if (drop_at > 0 && busy == drop_at) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
          mem_address   = ~a;
          mem_writedata = ~d;
        end
      end else begin
        done = 1;
      end
    end
    check(wr ? "wr_latency" : "rd_latency", busy, LATENCY + 1);
    last_done_cyc = cyc;
    if (done) check("err_in_done", {31'd0, mem_error}, 32'd0);
    if (!wr) begin
      exp = exp_q.pop_front();
      if (done) check("rd_data", mem_readdata, exp);
      last_rd = exp;
    end else if (done) begin
      check("wr_keeps_rdata", mem_readdata, last_rd);
    end
    @(posedge clock);
    #1;
    if (!keep) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  initial begin
    int          t_start;
    logic [31:0] v;
    logic [5:0]  ra;

    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_writedata = '0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", {31'd0, mem_busywait}, 32'd0);
    check("rst_err", {31'd0, mem_error}, 32'd0);
    check("rst_rdata", mem_readdata, 32'd0);
    @(posedge clock);
    #1;

    // T1 read of a reset word
    access(0, 6'h05, '0, 0, 0);

    // T2 write then read back
    access(1, 6'h0A, 32'hDEADBEEF, 0, 0);
    access(0, 6'h0A, '0, 0, 0);

    // T3 write held through DONE, refill taken in the following idle cycle
    t_start = cyc;
    access(1, 6'h11, 32'hA5A5A5A5, 0, 1);
    access(0, 6'h11, '0, 0, 0);
    check("wb_refill_cycles", last_done_cyc - t_start, 32'd13);

    // T4 request dropped two cycles into ACCESS
    access(1, 6'h3F, 32'h0BADF00D, 0, 0);
    access(0, 6'h3F, '0, 3, 0);

    // T6 both requests high in idle
    mem_read = 1'b1;
    mem_write = 1'b1;
    mem_address = 6'h0A;
    mem_writedata = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("both_err", {31'd0, mem_error}, 32'd1);
      check("both_busy", {31'd0, mem_busywait}, 32'd0);
      @(posedge clock);
      #1;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    access(0, 6'h0A, '0, 0, 0);

    // Random write/read pairs
    for (int k = 0; k < 4; k++) begin
      ra = 6'($urandom_range(0, 63));
      v  = $urandom;
      access(1, ra, v, 0, 0);
      access(0, ra, '0, 0, 0);
    end

    // T5 reset during the third ACCESS cycle of a write
    mem_address = 6'h20;
    mem_writedata = 32'h12345678;
    mem_write = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    mem_write = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_model();
    @(negedge clock);
    check("abort_busy", {31'd0, mem_busywait}, 32'd0);
    check("abort_rdata", mem_readdata, 32'd0);
    @(posedge clock);
    #1;
    access(0, 6'h20, '0, 0, 0);
    access(0, 6'h11, '0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
